// File: rtl/wb_tia_audio.sv
// TIA-compatible multi-channel sound generator on a Wishbone slave port.
// Each channel has a frequency divider and poly/divider waveform logic. Channel outputs feed a volume mixer and a sigma-delta PDM bit.
module wb_tia_audio #(
  parameter int NUM_CHANNELS  = 2,
  parameter int WB_ADDR_WIDTH = 5,
  parameter int WB_DATA_WIDTH = 8,
  parameter int CLK_DIV       = 510,
  parameter int MIX_W         = 4 + $clog2(NUM_CHANNELS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic                     ack_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  output logic [MIX_W-1:0]         sample_o,
  output logic                     sample_valid_o,
  output logic                     pdm_o
);

  localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [WB_ADDR_WIDTH-1:0] CTRL_ADR = WB_ADDR_WIDTH'(3 * NUM_CHANNELS);

  logic [3:0] audc [NUM_CHANNELS];
  logic [4:0] audf [NUM_CHANNELS];
  logic [3:0] audv [NUM_CHANNELS];
  logic       enable;
  logic       lfsr_rst;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              vld_p0;

  logic [4:0] div_cnt  [NUM_CHANNELS];
  logic [6:0] step_cnt [NUM_CHANNELS];
  logic [3:0] poly4    [NUM_CHANNELS];
  logic [4:0] poly5    [NUM_CHANNELS];
  logic [8:0] poly9    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] chan_out;

  logic [3:0] p4_nxt [NUM_CHANNELS];
  logic [4:0] p5_nxt [NUM_CHANNELS];
  logic [8:0] p9_nxt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] out_nxt;
  logic [NUM_CHANNELS-1:0] step_hit;

  logic [MIX_W-1:0]         mix_sum;
  logic [MIX_W-1:0]         pdm_acc;
  logic [MIX_W:0]           pdm_sum;
  logic [WB_DATA_WIDTH-1:0] rd_data;
  logic                     wr_en;
  logic                     unused_dat;

  function automatic logic [3:0] lfsr4(input logic [3:0] p);
    return {p[2:0], p[3] ^ p[2]};
  endfunction

  function automatic logic [4:0] lfsr5(input logic [4:0] p);
    return {p[3:0], p[4] ^ p[2]};
  endfunction

  function automatic logic [8:0] lfsr9(input logic [8:0] p);
    return {p[7:0], p[8] ^ p[4]};
  endfunction

  // Modes 2 and 3 gate the 4-bit poly; every other mode clocks it each step.
  function automatic logic poly4_adv(input logic [3:0] mode, input logic [6:0] sc,
                                     input logic p5_msb);
    case (mode)
      4'd2:    return (sc % 7'd15) == 7'd0;
      4'd3:    return p5_msb;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic wave_out(input logic [3:0] mode, input logic cur,
                                    input logic [6:0] sc, input logic p5_msb,
                                    input logic p4n, input logic p5n, input logic p9n);
    case (mode)
      4'd0, 4'd11:       return 1'b1;
      4'd1, 4'd2, 4'd3:  return p4n;
      4'd4, 4'd5:        return ~cur;
      4'd6, 4'd10:       return ((sc % 7'd31) == 7'd0) ? ~cur : cur;
      4'd7, 4'd9:        return p5n;
      4'd8:              return p9n;
      4'd12, 4'd13:      return ((sc % 7'd3) == 7'd0) ? ~cur : cur;
      4'd14:             return (sc == 7'd0) ? ~cur : cur;
      default:           return (((sc % 7'd3) == 7'd0) && p5_msb) ? ~cur : cur;
    endcase
  endfunction

  assign tick       = (tick_cnt == TICK_W'(CLK_DIV - 1));
  assign wr_en      = stb_i & we_i;
  assign pdm_sum    = {1'b0, pdm_acc} + {1'b0, sample_o};
  assign unused_dat = ^dat_i;

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (adr_i == WB_ADDR_WIDTH'(3 * c))     rd_data = WB_DATA_WIDTH'(audc[c]);
      if (adr_i == WB_ADDR_WIDTH'(3 * c + 1)) rd_data = WB_DATA_WIDTH'(audf[c]);
      if (adr_i == WB_ADDR_WIDTH'(3 * c + 2)) rd_data = WB_DATA_WIDTH'(audv[c]);
    end
    if (adr_i == CTRL_ADR) rd_data = WB_DATA_WIDTH'(enable);
  end

  always_comb begin
    step_hit = '0;
    out_nxt  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      step_hit[c] = (div_cnt[c] >= audf[c]);
      p4_nxt[c]   = poly4_adv(audc[c], step_cnt[c], poly5[c][4]) ? lfsr4(poly4[c]) : poly4[c];
      p5_nxt[c]   = lfsr5(poly5[c]);
      p9_nxt[c]   = lfsr9(poly9[c]);
      out_nxt[c]  = wave_out(audc[c], chan_out[c], step_cnt[c], poly5[c][4],
                             p4_nxt[c][3], p5_nxt[c][4], p9_nxt[c][8]);
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (chan_out[c]) mix_sum = mix_sum + MIX_W'(audv[c]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o          <= 1'b0;
      dat_o          <= '0;
      enable         <= 1'b1;
      lfsr_rst       <= 1'b0;
      tick_cnt       <= '0;
      vld_p0         <= 1'b0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      pdm_acc        <= '0;
      pdm_o          <= 1'b0;
      chan_out       <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        audc[c]     <= '0;
        audf[c]     <= '0;
        audv[c]     <= '0;
        div_cnt[c]  <= '0;
        step_cnt[c] <= '0;
        poly4[c]    <= 4'hF;
        poly5[c]    <= 5'h1F;
        poly9[c]    <= 9'h1FF;
      end
    end else begin
      ack_o <= stb_i;
      if (stb_i && !we_i) dat_o <= rd_data;

      lfsr_rst <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (wr_en && adr_i == WB_ADDR_WIDTH'(3 * c))     audc[c] <= dat_i[3:0];
        if (wr_en && adr_i == WB_ADDR_WIDTH'(3 * c + 1)) audf[c] <= dat_i[4:0];
        if (wr_en && adr_i == WB_ADDR_WIDTH'(3 * c + 2)) audv[c] <= dat_i[3:0];
      end
      if (wr_en && adr_i == CTRL_ADR) begin
        enable   <= dat_i[0];
        lfsr_rst <= dat_i[1];
      end

      // p0: tick generation and channel stepping
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      vld_p0   <= tick;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (lfsr_rst) begin
          div_cnt[c]  <= '0;
          step_cnt[c] <= '0;
          poly4[c]    <= 4'hF;
          poly5[c]    <= 5'h1F;
          poly9[c]    <= 9'h1FF;
        end else if (tick && enable) begin
          if (step_hit[c]) begin
            div_cnt[c]  <= '0;
            step_cnt[c] <= (step_cnt[c] == 7'd92) ? 7'd0 : step_cnt[c] + 7'd1;
            poly4[c]    <= p4_nxt[c];
            poly5[c]    <= p5_nxt[c];
            poly9[c]    <= p9_nxt[c];
            chan_out[c] <= out_nxt[c];
          end else begin
            div_cnt[c] <= div_cnt[c] + 5'd1;
          end
        end
      end

      // p1: mixed sample, one cycle after the tick
      sample_valid_o <= vld_p0;
      if (vld_p0) sample_o <= enable ? mix_sum : '0;

      pdm_acc <= pdm_sum[MIX_W-1:0];
      pdm_o   <= pdm_sum[MIX_W];
    end
  end

endmodule
